kd_node_tree: RTL
=================

// Module: kd_node_tree
// PURPOSE
//  Internal-node store and traversal pipeline of the k-d tree. Sits downstream of wbsCtrl's node-memory
//  port (web/addr/wdata/rdata), holds NUM_LEAVES-1 split nodes, and walks each query patch root-to-leaf
//  to produce a leaf index for the leaf-memory search stage. One query per cycle, fixed latency.
// PARAMETERS
//  DATA_WIDTH  11   bits per patch element and per median (signed two's complement)
//  PATCH_SIZE  5    elements per query patch
//  NUM_LEAVES  64   leaves (power of 2); NUM_NODES = NUM_LEAVES-1; LEVELS = LEAF_ADDRW = $clog2(NUM_LEAVES)
//  IDX_W       3    width of node split-dimension index
//  NUM_QUERYS  408  queries per frame; TAG_W = $clog2(NUM_QUERYS)
// PORTS
//  wb_clk_i            in   1                      clock
//  wb_rst_i            in   1                      synchronous active-high reset
//  wbs_mode            in   1                      1 = Wishbone owns node memory, 0 = traversal mode
//  wbs_node_mem_web    in   1                      active-low write enable
//  wbs_node_mem_addr   in   32                     node address
//  wbs_node_mem_wdata  in   32                     node write word
//  wbs_node_mem_rdata  out  32                     node read word
//  in_valid            in   1                      query handshake
//  in_ready            out  1
//  in_patch            in   PATCH_SIZE*DATA_WIDTH  query patch, [PATCH_SIZE-1:0][DATA_WIDTH-1:0]
//  in_tag              in   TAG_W                  query index, passed through
//  out_valid           out  1                      result handshake
//  out_ready           in   1
//  out_leaf_idx        out  LEAF_ADDRW             selected leaf
//  out_patch           out  PATCH_SIZE*DATA_WIDTH  patch passthrough
//  out_tag             out  TAG_W                  tag passthrough
//  busy                out  1                      any pipeline stage holds a valid query
// BEHAVIOUR
//  - Node word: [IDX_W-1:0] = split dim; [2*DATA_WIDTH-1:DATA_WIDTH] = median; all other bits 0 on read,
//    ignored on write.
//  - Reset (synchronous): every node = {median 0, idx 3'b111}; rdata = 0; all stage valids = 0;
//    out_valid = 0; busy = 0.
//  - Node select = addr[LEAF_ADDRW-1:0]. Selects >= NUM_NODES: writes dropped, reads return 0.
//  - Write: committed at the clock edge where web=0 and wbs_mode=1 and busy=0. Dropped otherwise.
//  - Read: rdata <= node[addr] every cycle (1-cycle latency, independent of web/mode). A same-cycle write
//    returns the old value.
//  - Heap layout: root = node 0; children of n = 2n+1 (left) and 2n+2 (right).
//  - Step: if idx >= PATCH_SIZE, go left. Otherwise go left iff $signed(patch[idx]) < $signed(median),
//    else go right (ties go right).
//  - Leaf = final node - NUM_NODES.
//  - Pipeline: LEVELS registered stages, one tree level per stage.
//  - Handshake: accept when in_valid & in_ready. Result appears LEVELS cycles later with
//    out_valid = 1 and out_leaf_idx/out_patch/out_tag stable until out_ready.
//  - in_ready = ~wbs_mode & ~(out_valid & ~out_ready).
//  - Stall: out_valid & ~out_ready freezes the whole pipeline. No bubbles are squeezed, no loss,
//    order preserved.
//  - wbs_mode rising with queries in flight: no new accepts; in-flight queries drain using current
//    node contents; writes are held off until busy = 0.
//  - Node content is read combinationally per stage.
//  - Reset mid-traversal: all in-flight queries are discarded; out_valid = 0 on the next cycle.
// TESTING
//  1 Reset, mode 0, addr=1 -> next cycle rdata = 32'h0000_0007; in_ready = 1; out_valid = 0.
//  2 mode=1, write addr 1 wdata {10'b0,11'd55,11'd1}, then read addr 1 -> rdata = 32'h0001_B801.
//    Write at addr 63 -> dropped; read addr 63 -> 0.
//  3 mode=0, write addr 2 -> dropped (rdata unchanged).
//    All nodes {idx 0, median 0}; patch[0] = 5 -> out_leaf_idx = 63 after 6 cycles.
//    patch[0] = -5 -> out_leaf_idx = 0.
//  4 Random tree plus 8 back-to-back queries, out_ready toggled pseudo-randomly -> leaf indices match
//    the reference model; tags are in order; none dropped or duplicated.
//  5 Set mode=1 with 3 queries in flight, web=0 -> write deferred until busy = 0; the 3 results use
//    the old tree.
//  6 Assert wb_rst_i with pipeline full -> out_valid = 0 and busy = 0 the next cycle; nodes read
//    back at default.

Source files
------------

// File: rtl/kd_node_tree.sv
// kd_node_tree: k-d tree split-node store plus a LEVELS-deep traversal
// pipeline mapping each query patch to a leaf index, one query per cycle.
module kd_node_tree #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64,
    parameter int IDX_W      = 3,
    parameter int NUM_QUERYS = 408,
    localparam int LEAF_ADDRW = $clog2(NUM_LEAVES),
    localparam int TAG_W      = $clog2(NUM_QUERYS),
    localparam int PW         = PATCH_SIZE * DATA_WIDTH
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_mode,
    input  logic                  wbs_node_mem_web,
    input  logic [31:0]           wbs_node_mem_addr,
    input  logic [31:0]           wbs_node_mem_wdata,
    output logic [31:0]           wbs_node_mem_rdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PW-1:0]         in_patch,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LEAF_ADDRW-1:0] out_leaf_idx,
    output logic [PW-1:0]         out_patch,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);
    localparam int NUM_NODES = NUM_LEAVES - 1;
    localparam int LEVELS    = LEAF_ADDRW;
    localparam int NODE_W    = LEAF_ADDRW + 1;

    logic [DATA_WIDTH-1:0] med_q [NUM_NODES];
    logic [DATA_WIDTH-1:0] med_d [NUM_NODES];
    logic [IDX_W-1:0]      idx_q [NUM_NODES];
    logic [IDX_W-1:0]      idx_d [NUM_NODES];
    logic [31:0]           rdata_q, rdata_d;

    logic [LEVELS-1:0]             vld_all;
    logic [LEVELS-1:0][NODE_W-1:0] node_all;
    logic [LEVELS-1:0][PW-1:0]     patch_all;
    logic [LEVELS-1:0][TAG_W-1:0]  tag_all;

    logic [LEAF_ADDRW-1:0] sel;
    logic [NODE_W-1:0]     leaf_full;
    logic                  sel_ok, wr_en, adv, unused;

    assign sel       = wbs_node_mem_addr[LEAF_ADDRW-1:0];
    assign sel_ok    = sel < LEAF_ADDRW'(NUM_NODES);
    assign busy      = |vld_all;
    assign out_valid = vld_all[LEVELS-1];
    assign adv       = ~(out_valid & ~out_ready);
    assign in_ready  = ~wbs_mode & adv;
    // Writes wait for an empty pipeline so in-flight queries see one tree.
    assign wr_en     = ~wbs_node_mem_web & wbs_mode & ~busy & sel_ok;

    assign leaf_full          = node_all[LEVELS-1] - NODE_W'(NUM_NODES);
    assign out_leaf_idx       = leaf_full[LEAF_ADDRW-1:0];
    assign out_patch          = patch_all[LEVELS-1];
    assign out_tag            = tag_all[LEVELS-1];
    assign wbs_node_mem_rdata = rdata_q;

    assign unused = ^{wbs_node_mem_addr[31:LEAF_ADDRW],
                      wbs_node_mem_wdata[31:2*DATA_WIDTH],
                      wbs_node_mem_wdata[DATA_WIDTH-1:IDX_W],
                      leaf_full[NODE_W-1]};

    always_comb begin
        med_d   = med_q;
        idx_d   = idx_q;
        rdata_d = '0;
        if (wr_en) begin
            med_d[sel] = wbs_node_mem_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            idx_d[sel] = wbs_node_mem_wdata[IDX_W-1:0];
        end
        if (sel_ok) begin
            rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = med_q[sel];
            rdata_d[IDX_W-1:0]                 = idx_q[sel];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                med_q[i] <= '0;
                idx_q[i] <= '1;
            end
            rdata_q <= '0;
        end else begin
            med_q   <= med_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        logic                         vin;
        logic [NODE_W-1:0]            n_in;
        logic [PW-1:0]                p_in;
        logic [TAG_W-1:0]             t_in;
        logic [LEAF_ADDRW-1:0]        nsel;
        logic [IDX_W-1:0]             dim;
        logic signed [DATA_WIDTH-1:0] med;
        logic signed [DATA_WIDTH-1:0] elem;
        logic                         right;
        logic                         vld_q, vld_d;
        logic [NODE_W-1:0]            node_q, node_d;
        logic [PW-1:0]                patch_q, patch_d;
        logic [TAG_W-1:0]             tag_q, tag_d;

        if (s == 0) begin : g_root
            assign vin  = in_valid & in_ready;
            assign n_in = '0;
            assign p_in = in_patch;
            assign t_in = in_tag;
        end else begin : g_lvl
            assign vin  = vld_all[s-1];
            assign n_in = node_all[s-1];
            assign p_in = patch_all[s-1];
            assign t_in = tag_all[s-1];
        end

        assign nsel = n_in[LEAF_ADDRW-1:0];

        // Out-of-range dims steer left; ties on the median steer right.
        always_comb begin
            med   = '0;
            dim   = '1;
            elem  = '0;
            right = 1'b0;
            if (n_in < NODE_W'(NUM_NODES)) begin
                med = med_q[nsel];
                dim = idx_q[nsel];
            end
            for (int k = 0; k < PATCH_SIZE; k++) begin
                if (dim == IDX_W'(k)) elem = p_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (dim < IDX_W'(PATCH_SIZE)) right = ~(elem < med);
        end

        always_comb begin
            vld_d   = vld_q;
            node_d  = node_q;
            patch_d = patch_q;
            tag_d   = tag_q;
            if (adv) begin
                vld_d   = vin;
                node_d  = {n_in[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(right);
                patch_d = p_in;
                tag_d   = t_in;
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) vld_q <= 1'b0;
            else          vld_q <= vld_d;
            node_q  <= node_d;
            patch_q <= patch_d;
            tag_q   <= tag_d;
        end

        assign vld_all[s]   = vld_q;
        assign node_all[s]  = node_q;
        assign patch_all[s] = patch_q;
        assign tag_all[s]   = tag_q;
    end
endmodule
